// File: rtl/axichannel_replayer_pkg.sv
// -----------------------------------------------------------------------------
// axichannel_replayer_pkg
// Shared constants and types for the per-channel AXI replayer:
//   - replay mode selectors (who sources the channel payload)
//   - default payload/FIFO/credit sizing
//   - credit update event type used by the top-level credit counter
// -----------------------------------------------------------------------------
package axichannel_replayer_pkg;

    // Replay mode: the replayer either drives valid+payload (source) or only
    // gates the ready of a channel whose payload the DUT produces (sink).
    localparam bit RR_REPLAY_SOURCE = 1'b1;
    localparam bit RR_REPLAY_SINK   = 1'b0;

    localparam int unsigned RR_DEFAULT_DATA_WIDTH   = 64;
    localparam int unsigned RR_DEFAULT_FIFO_DEPTH   = 4;
    localparam int unsigned RR_DEFAULT_CREDIT_WIDTH = 8;
    localparam int unsigned RR_HS_COUNT_WIDTH       = 32;

    // Per-cycle credit events: a logged event token arriving and a channel
    // handshake consuming one. Both at once leave the count unchanged.
    typedef struct packed {
        logic token;
        logic handshake;
    } credit_evt_t;

endpackage : axichannel_replayer_pkg

// File: rtl/axichannel_replayer_fifo.sv
// -----------------------------------------------------------------------------
// axichannel_replayer_fifo
// Synchronous show-ahead FIFO buffering logged payloads until their recorded
// handshake is released. The head entry is visible on head_o whenever the
// FIFO is not empty; pushes into a full FIFO and pops from an empty FIFO are
// ignored. DEPTH must be a power of two, >= 2.
//
// Ports
//   clk      in   1      clock
//   rstn     in   1      asynchronous active-low reset (empties the FIFO)
//   push_i   in   1      write data_i at the tail
//   data_i   in   WIDTH  payload to write
//   pop_i    in   1      drop the head entry
//   head_o   out  WIDTH  current head entry (meaningful only when !empty_o)
//   full_o   out  1      DEPTH entries stored
//   empty_o  out  1      no entries stored
// -----------------------------------------------------------------------------
module axichannel_replayer_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; emptying the FIFO only
    // needs the pointers, and stale entries are never observable because the
    // top masks the head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule : axichannel_replayer_fifo

// File: rtl/axichannel_replayer.sv
// -----------------------------------------------------------------------------
// axichannel_replayer
// Replay-side counterpart of the per-channel AXI logger. Re-drives one AXI
// channel from recorded log entries: payloads arrive on the logb stream,
// recorded handshake events arrive as loge tokens, and the channel completes
// exactly one handshake per token, in recorded order.
//
// IS_SOURCE=1: the replayer buffers payloads and drives out_valid/out_data.
// IS_SOURCE=0: the DUT drives the channel; the replayer only gates in_ready.
//
// Ports
//   clk             in   1             clock
//   rstn            in   1             asynchronous active-low reset
//   rep_logb_valid  in   1             logged payload available
//   rep_logb_ready  out  1             payload accepted
//   rep_logb_data   in   DATA_WIDTH    logged payload
//   rep_loge_valid  in   1             one logged handshake event
//   rep_loge_ready  out  1             event token accepted
//   out_valid       out  1             channel valid toward DUT (source mode)
//   out_ready       in   1             channel ready from DUT
//   out_data        out  DATA_WIDTH    channel payload toward DUT
//   in_valid        in   1             channel valid from DUT (sink mode)
//   in_ready        out  1             channel ready toward DUT
//   credits         out  CREDIT_WIDTH  unspent event tokens
//   hs_count        out  32            completed handshakes, wraps mod 2**32
//   idle            out  1             no credits and no buffered payload
// -----------------------------------------------------------------------------
module axichannel_replayer
    import axichannel_replayer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = RR_DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH   = RR_DEFAULT_FIFO_DEPTH,
    parameter int unsigned CREDIT_WIDTH = RR_DEFAULT_CREDIT_WIDTH,
    parameter bit          IS_SOURCE    = RR_REPLAY_SOURCE
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         rep_logb_valid,
    output logic                         rep_logb_ready,
    input  logic [DATA_WIDTH-1:0]        rep_logb_data,
    input  logic                         rep_loge_valid,
    output logic                         rep_loge_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CREDIT_WIDTH-1:0]      credits,
    output logic [RR_HS_COUNT_WIDTH-1:0] hs_count,
    output logic                         idle
);

    localparam logic [CREDIT_WIDTH-1:0]      CREDIT_MAX = '1;
    localparam logic [CREDIT_WIDTH-1:0]      CREDIT_ONE = CREDIT_WIDTH'(1);
    localparam logic [RR_HS_COUNT_WIDTH-1:0] HS_ONE     = RR_HS_COUNT_WIDTH'(1);

    logic [CREDIT_WIDTH-1:0]      credits_q, credits_d;
    logic [RR_HS_COUNT_WIDTH-1:0] hs_count_q, hs_count_d;
    logic                         credits_nz;
    logic                         token_accept;
    logic                         handshake;
    logic                         fifo_empty;
    credit_evt_t                  evt;

    // A saturated counter refuses further tokens, so it can never wrap.
    assign rep_loge_ready = (credits_q != CREDIT_MAX);
    assign token_accept   = rep_loge_valid && rep_loge_ready;
    assign credits_nz     = (credits_q != '0);

    generate
        if (IS_SOURCE == RR_REPLAY_SOURCE) begin : g_source
            logic                  fifo_full;
            logic [DATA_WIDTH-1:0] fifo_head;
            logic                  unused_sink;

            axichannel_replayer_fifo #(
                .WIDTH (DATA_WIDTH),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rstn    (rstn),
                .push_i  (rep_logb_valid),
                .data_i  (rep_logb_data),
                .pop_i   (handshake),
                .head_o  (fifo_head),
                .full_o  (fifo_full),
                .empty_o (fifo_empty)
            );

            // No pop-through when full: a full FIFO refuses the payload even
            // if the head leaves in the same cycle, keeping ready off the
            // DUT-facing handshake path.
            assign rep_logb_ready = !fifo_full;

            // out_valid stays asserted with a stable head until the handshake,
            // because only that handshake decrements credits or pops the FIFO.
            assign out_valid = !fifo_empty && credits_nz;
            assign out_data  = out_valid ? fifo_head : '0;
            assign handshake = out_valid && out_ready;
            assign in_ready  = 1'b0;

            assign unused_sink = in_valid;
        end else begin : g_sink
            logic unused_source;

            // No payload storage in sink mode; ready comes straight from the
            // registered credit count.
            assign fifo_empty     = 1'b1;
            assign rep_logb_ready = 1'b0;
            assign out_valid      = 1'b0;
            assign out_data       = '0;
            assign in_ready       = credits_nz;
            assign handshake      = in_valid && in_ready;

            assign unused_source = ^{rep_logb_valid, rep_logb_data, out_ready};
        end
    endgenerate

    // Credit update: a handshake can only occur with credits != 0 and a token
    // is only taken below the maximum, so neither direction can overflow.
    always_comb begin
        evt        = '{token: token_accept, handshake: handshake};
        credits_d  = credits_q;
        hs_count_d = hs_count_q;
        if (evt.token && !evt.handshake) begin
            credits_d = credits_q + CREDIT_ONE;
        end else if (!evt.token && evt.handshake) begin
            credits_d = credits_q - CREDIT_ONE;
        end
        if (evt.handshake) begin
            hs_count_d = hs_count_q + HS_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credits_q  <= '0;
            hs_count_q <= '0;
        end else begin
            credits_q  <= credits_d;
            hs_count_q <= hs_count_d;
        end
    end

    assign credits  = credits_q;
    assign hs_count = hs_count_q;
    assign idle     = !credits_nz && fifo_empty;

endmodule : axichannel_replayer

// File: tb/tb_axichannel_replayer.sv
// -----------------------------------------------------------------------------
// tb_axichannel_replayer
// Bench for axichannel_replayer: one source-mode and one sink-mode instance
// share clock and reset. A hand-checked vector table covers the basic source
// flow, directed sequences cover the multi-cycle corners, and a randomized
// phase compares both instances against a queue/counter reference model.
// -----------------------------------------------------------------------------
module tb_axichannel_replayer;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 8;
    localparam int          CMAX  = (1 << CW) - 1;

    logic clk;
    logic rstn;

    // source-mode instance
    logic          s_logb_valid, s_logb_ready, s_loge_valid, s_loge_ready;
    logic [DW-1:0] s_logb_data, s_out_data;
    logic          s_out_valid, s_out_ready, s_in_valid, s_in_ready, s_idle;
    logic [CW-1:0] s_credits;
    logic [31:0]   s_hs_count;

    // sink-mode instance
    logic          k_logb_valid, k_logb_ready, k_loge_valid, k_loge_ready;
    logic [DW-1:0] k_logb_data, k_out_data;
    logic          k_out_valid, k_out_ready, k_in_valid, k_in_ready, k_idle;
    logic [CW-1:0] k_credits;
    logic [31:0]   k_hs_count;

    axichannel_replayer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CREDIT_WIDTH(CW), .IS_SOURCE(1'b1)
    ) u_src (
        .clk(clk), .rstn(rstn),
        .rep_logb_valid(s_logb_valid), .rep_logb_ready(s_logb_ready),
        .rep_logb_data(s_logb_data),
        .rep_loge_valid(s_loge_valid), .rep_loge_ready(s_loge_ready),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .credits(s_credits), .hs_count(s_hs_count), .idle(s_idle)
    );

    axichannel_replayer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CREDIT_WIDTH(CW), .IS_SOURCE(1'b0)
    ) u_snk (
        .clk(clk), .rstn(rstn),
        .rep_logb_valid(k_logb_valid), .rep_logb_ready(k_logb_ready),
        .rep_logb_data(k_logb_data),
        .rep_loge_valid(k_loge_valid), .rep_loge_ready(k_loge_ready),
        .out_valid(k_out_valid), .out_ready(k_out_ready), .out_data(k_out_data),
        .in_valid(k_in_valid), .in_ready(k_in_ready),
        .credits(k_credits), .hs_count(k_hs_count), .idle(k_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] src_q[$];
    int            src_cr;
    int unsigned   src_hs;
    int            snk_cr;
    int unsigned   snk_hs;

    task automatic model_reset();
        src_q.delete();
        src_cr = 0;
        src_hs = 0;
        snk_cr = 0;
        snk_hs = 0;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        bit s_vld, s_hs, s_push, s_tok, k_hs, k_tok;
        s_vld  = (src_q.size() != 0) && (src_cr != 0);
        s_hs   = s_vld && s_out_ready;
        s_push = s_logb_valid && (src_q.size() < DEPTH);
        s_tok  = s_loge_valid && (src_cr != CMAX);
        if (s_hs) begin
            void'(src_q.pop_front());
            src_hs++;
        end
        if (s_push) src_q.push_back(s_logb_data);
        src_cr = src_cr + int'(s_tok) - int'(s_hs);

        k_hs  = (snk_cr != 0) && k_in_valid;
        k_tok = k_loge_valid && (snk_cr != CMAX);
        if (k_hs) snk_hs++;
        snk_cr = snk_cr + int'(k_tok) - int'(k_hs);
    endtask

    task automatic model_check(input string tag);
        bit          vld;
        logic [63:0] dat;
        vld = (src_q.size() != 0) && (src_cr != 0);
        dat = vld ? src_q[0] : 64'h0;
        check({tag, " src out_valid"},  s_out_valid,  vld);
        check({tag, " src out_data"},   s_out_data,   dat);
        check({tag, " src credits"},    s_credits,    src_cr);
        check({tag, " src hs_count"},   s_hs_count,   src_hs);
        check({tag, " src logb_ready"}, s_logb_ready, src_q.size() < DEPTH);
        check({tag, " src loge_ready"}, s_loge_ready, src_cr != CMAX);
        check({tag, " src idle"},       s_idle,       (src_cr == 0) && (src_q.size() == 0));
        check({tag, " src in_ready"},   s_in_ready,   1'b0);
        check({tag, " snk in_ready"},   k_in_ready,   snk_cr != 0);
        check({tag, " snk credits"},    k_credits,    snk_cr);
        check({tag, " snk hs_count"},   k_hs_count,   snk_hs);
        check({tag, " snk loge_ready"}, k_loge_ready, snk_cr != CMAX);
        check({tag, " snk idle"},       k_idle,       snk_cr == 0);
        check({tag, " snk out_valid"},  k_out_valid,  1'b0);
        check({tag, " snk logb_ready"}, k_logb_ready, 1'b0);
    endtask

    task automatic zero_inputs();
        s_logb_valid = 1'b0; s_logb_data = '0; s_loge_valid = 1'b0;
        s_out_ready  = 1'b0; s_in_valid  = 1'b0;
        k_logb_valid = 1'b0; k_logb_data = '0; k_loge_valid = 1'b0;
        k_out_ready  = 1'b0; k_in_valid  = 1'b0;
    endtask

    // Assert reset away from the edge, release on a falling edge.
    task automatic do_reset();
        zero_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          logb_valid;
        logic [DW-1:0] logb_data;
        logic          loge_valid;
        logic          out_ready;
        logic          exp_out_valid;
        logic [DW-1:0] exp_out_data;
        int            exp_credits;
        int            exp_hs;
        logic          exp_logb_ready;
        logic          exp_idle;
    } vec_t;

    localparam logic [DW-1:0] VA = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] VB = 64'hFEDC_BA98_7654_3210;
    localparam logic [DW-1:0] VC = 64'hA5A5_0000_5A5A_FFFF;
    localparam logic [DW-1:0] VD = 64'h0000_0000_0000_00D0;
    localparam logic [DW-1:0] VE = 64'h0000_0000_0000_00E0;
    localparam logic [DW-1:0] VF = 64'h0000_0000_0000_00F0;
    localparam logic [DW-1:0] VG = 64'h0000_0000_0000_0060;
    localparam logic [DW-1:0] VH = 64'h0000_0000_0000_0070;

    vec_t vecs[14];

    initial begin
        // Each row: inputs held for one clock, expected outputs after that edge.
        vecs[0]  = '{1'b1, VA, 1'b0, 1'b1, 1'b0, 64'h0, 0, 0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, VB, 1'b0, 1'b1, 1'b0, 64'h0, 0, 0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, VC, 1'b0, 1'b1, 1'b0, 64'h0, 0, 0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, VA, 1, 0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, VB, 1, 1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, VC, 1, 2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 0, 3, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, VD, 1'b0, 1'b0, 1'b0, 64'h0, 0, 3, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, VE, 1'b0, 1'b0, 1'b0, 64'h0, 0, 3, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, VF, 1'b0, 1'b0, 1'b0, 64'h0, 0, 3, 1'b1, 1'b0};
        vecs[10] = '{1'b1, VG, 1'b0, 1'b0, 1'b0, 64'h0, 0, 3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, VH, 1'b0, 1'b0, 1'b0, 64'h0, 0, 3, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, VD, 1, 3, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 0, 4, 1'b1, 1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] held;

        zero_inputs();
        rstn = 1'b0;
        #12;

        // Reset values while reset is held.
        check("rst src out_valid",  s_out_valid,  1'b0);
        check("rst src out_data",   s_out_data,   64'h0);
        check("rst src in_ready",   s_in_ready,   1'b0);
        check("rst src idle",       s_idle,       1'b1);
        check("rst src loge_ready", s_loge_ready, 1'b1);
        check("rst src logb_ready", s_logb_ready, 1'b1);
        check("rst src credits",    s_credits,    0);
        check("rst src hs_count",   s_hs_count,   0);
        check("rst snk logb_ready", k_logb_ready, 1'b0);
        check("rst snk in_ready",   k_in_ready,   1'b0);
        check("rst snk idle",       k_idle,       1'b1);

        do_reset();

        // Table: A,B,C then 3 tokens, then fill-to-full with stalled ready.
        for (int i = 0; i < 14; i++) begin
            s_logb_valid = vecs[i].logb_valid;
            s_logb_data  = vecs[i].logb_data;
            s_loge_valid = vecs[i].loge_valid;
            s_out_ready  = vecs[i].out_ready;
            cycle();
            check($sformatf("vec%0d out_valid", i),  s_out_valid,  vecs[i].exp_out_valid);
            check($sformatf("vec%0d out_data", i),   s_out_data,   vecs[i].exp_out_data);
            check($sformatf("vec%0d credits", i),    s_credits,    vecs[i].exp_credits);
            check($sformatf("vec%0d hs_count", i),   s_hs_count,   vecs[i].exp_hs);
            check($sformatf("vec%0d logb_ready", i), s_logb_ready, vecs[i].exp_logb_ready);
            check($sformatf("vec%0d idle", i),       s_idle,       vecs[i].exp_idle);
        end

        // Tokens before payload: valid only once the payload lands.
        do_reset();
        s_out_ready  = 1'b1;
        s_loge_valid = 1'b1;
        cycle();
        cycle();
        s_loge_valid = 1'b0;
        check("tok-first credits",   s_credits,   2);
        check("tok-first no valid",  s_out_valid, 1'b0);
        s_logb_valid = 1'b1;
        s_logb_data  = 64'h55;
        cycle();
        s_logb_valid = 1'b0;
        check("tok-first valid",     s_out_valid, 1'b1);
        check("tok-first data",      s_out_data,  64'h55);
        cycle();
        check("tok-first credits after", s_credits,   1);
        check("tok-first valid after",   s_out_valid, 1'b0);
        check("tok-first hs_count",      s_hs_count,  1);

        // Stalled ready: valid/data hold while the FIFO fills behind them.
        do_reset();
        s_loge_valid = 1'b1;
        s_logb_valid = 1'b1;
        s_logb_data  = 64'h100;
        cycle();
        s_loge_valid = 1'b0;
        held = s_out_data;
        check("stall first data", held, 64'h100);
        for (int i = 0; i < 10; i++) begin
            s_logb_data = 64'h200 + 64'(i);
            cycle();
            check($sformatf("stall%0d out_valid", i),  s_out_valid,  1'b1);
            check($sformatf("stall%0d out_data", i),   s_out_data,   held);
            check($sformatf("stall%0d logb_ready", i), s_logb_ready, i < 2);
        end
        s_logb_valid = 1'b0;
        s_out_ready  = 1'b1;
        cycle();
        s_out_ready  = 1'b0;
        check("stall release hs",    s_hs_count,  1);
        check("stall release valid", s_out_valid, 1'b0);
        check("stall release ready", s_logb_ready, 1'b1);

        // Sink: credit saturation at the counter maximum.
        do_reset();
        k_loge_valid = 1'b1;
        repeat (CMAX + 5) cycle();
        k_loge_valid = 1'b0;
        check("sat credits",    k_credits,    CMAX);
        check("sat loge_ready", k_loge_ready, 1'b0);
        k_in_valid = 1'b1;
        cycle();
        k_in_valid = 1'b0;
        check("sat credits after hs",    k_credits,    CMAX - 1);
        check("sat loge_ready after hs", k_loge_ready, 1'b1);
        check("sat hs_count",            k_hs_count,   1);

        // Sink: token and handshake in the same cycle with one credit.
        do_reset();
        k_loge_valid = 1'b1;
        cycle();
        check("same-cycle pre credits",  k_credits,  1);
        check("same-cycle pre in_ready", k_in_ready, 1'b1);
        k_in_valid = 1'b1;
        cycle();
        k_loge_valid = 1'b0;
        k_in_valid   = 1'b0;
        check("same-cycle credits",  k_credits,  1);
        check("same-cycle in_ready", k_in_ready, 1'b1);
        check("same-cycle hs_count", k_hs_count, 1);

        // Reset mid-burst: 2 credits and 3 buffered payloads are discarded.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_logb_valid = 1'b1;
            s_logb_data  = 64'hE0 + 64'(i);
            s_loge_valid = (i < 3);
            cycle();
        end
        s_logb_valid = 1'b0;
        s_loge_valid = 1'b0;
        s_out_ready  = 1'b1;
        cycle();
        s_out_ready  = 1'b0;
        check("burst credits",  s_credits,  2);
        check("burst hs_count", s_hs_count, 1);
        rstn = 1'b0;
        #2;
        check("midrst out_valid", s_out_valid, 1'b0);
        check("midrst out_data",  s_out_data,  64'h0);
        check("midrst credits",   s_credits,   0);
        check("midrst hs_count",  s_hs_count,  0);
        check("midrst idle",      s_idle,      1'b1);
        @(negedge clk);
        rstn = 1'b1;
        s_loge_valid = 1'b1;
        cycle();
        s_loge_valid = 1'b0;
        s_out_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("post-rst%0d no stale valid", i), s_out_valid, 1'b0);
        end
        check("post-rst credits", s_credits, 1);
        s_out_ready = 1'b0;

        // Randomized traffic on both instances against the reference model.
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            s_logb_valid = ($urandom_range(0, 99) < 50);
            s_logb_data  = {$urandom(), $urandom()};
            s_loge_valid = ($urandom_range(0, 99) < 35);
            s_out_ready  = ($urandom_range(0, 99) < 60);
            s_in_valid   = ($urandom_range(0, 1) == 1);
            k_logb_valid = ($urandom_range(0, 1) == 1);
            k_logb_data  = {$urandom(), $urandom()};
            k_loge_valid = ($urandom_range(0, 99) < 40);
            k_in_valid   = ($urandom_range(0, 99) < 60);
            k_out_ready  = ($urandom_range(0, 1) == 1);
            model_step();
            cycle();
            model_check($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_axichannel_replayer
